// File: rtl/fcims_core.sv
// fcims_core: single-item sale/restock transaction engine.
// Prices a sale (uprice * ncel), debits stock, and accumulates the bill.
// A restock adds to stock with saturation. All outputs are registered.
// Holds no stock or bill state of its own; the caller feeds new_ct and
// tprice_final back in as ct and tprice_init.
// Build option: define FCIMS_SAT_EN to saturate the bill total on overflow
// instead of wrapping it modulo 2^TW.
// TW must be at least PW+QW so the full line price fits in the bill adder.
module fcims_core #(
  parameter int PW = 4,
  parameter int QW = 4,
  parameter int TW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl,
  input  logic [PW-1:0]    uprice,
  input  logic [QW-1:0]    ncel,
  input  logic [QW-1:0]    ct,
  input  logic [TW-1:0]    tprice_init,
  output logic [PW+QW-1:0] fprice,
  output logic [QW-1:0]    new_ct,
  output logic [TW-1:0]    tprice_final,
  output logic             reject,
  output logic             ovf
);

  localparam int FW = PW + QW;

  logic [FW-1:0] line_prod;
  logic [TW:0]   bill_sum;
  logic [QW:0]   stock_sum;
  logic          short_stock;

  logic [FW-1:0] fprice_d;
  logic [QW-1:0] new_ct_d;
  logic [TW-1:0] tprice_d;
  logic          reject_d;
  logic          ovf_d;

  // Arithmetic datapath: operands widened so no carry or product bit is lost.
  always_comb begin
    line_prod   = FW'(uprice) * FW'(ncel);
    bill_sum    = {1'b0, tprice_init} + (TW+1)'(line_prod);
    stock_sum   = {1'b0, ct} + {1'b0, ncel};
    short_stock = (ncel > ct);
  end

  // Transaction decode: select the next registered results for sale or restock.
  always_comb begin
    fprice_d = '0;
    new_ct_d = ct;
    tprice_d = tprice_init;
    reject_d = 1'b0;
    ovf_d    = 1'b0;
    if (ctrl) begin
      if (short_stock) begin
        reject_d = 1'b1;
      end else begin
        fprice_d = line_prod;
        new_ct_d = ct - ncel;
        ovf_d    = bill_sum[TW];
`ifdef FCIMS_SAT_EN
        tprice_d = bill_sum[TW] ? {TW{1'b1}} : bill_sum[TW-1:0];
`else
        tprice_d = bill_sum[TW-1:0];
`endif
      end
    end else begin
      // Restock saturates at full scale regardless of the bill build option.
      ovf_d    = stock_sum[QW];
      new_ct_d = stock_sum[QW] ? {QW{1'b1}} : stock_sum[QW-1:0];
    end
  end

  // Output register: cleared asynchronously while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fprice       <= '0;
      new_ct       <= '0;
      tprice_final <= '0;
      reject       <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      fprice       <= fprice_d;
      new_ct       <= new_ct_d;
      tprice_final <= tprice_d;
      reject       <= reject_d;
      ovf          <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fcims_core.sv
// Testbench for fcims_core: directed vector table, random vectors against an
// integer reference model, and a mid-cycle asynchronous reset sequence.
module tb_fcims_core;

  logic       clk;
  logic       reset;
  logic       ctrl;
  logic [3:0] uprice;
  logic [3:0] ncel;
  logic [3:0] ct;
  logic [7:0] tprice_init;
  logic [7:0] fprice;
  logic [3:0] new_ct;
  logic [7:0] tprice_final;
  logic       reject;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef FCIMS_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic       ctrl;
    logic [3:0] up;
    logic [3:0] n;
    logic [3:0] c;
    logic [7:0] ti;
    logic [7:0] fp;
    logic [3:0] nc;
    logic [7:0] tf;
    logic       rj;
    logic       ov;
  } vec_t;

  vec_t vecs[12];
  vec_t sb_q[$];

  fcims_core #(.PW(4), .QW(4), .TW(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .ctrl         (ctrl),
    .uprice       (uprice),
    .ncel         (ncel),
    .ct           (ct),
    .tprice_init  (tprice_init),
    .fprice       (fprice),
    .new_ct       (new_ct),
    .tprice_final (tprice_final),
    .reject       (reject),
    .ovf          (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic c_, input int up, input int n, input int c,
                              input int ti, input int fp, input int nc, input int tf,
                              input int rj, input int ov);
    vec_t v;
    v.ctrl = c_;
    v.up = 4'(up); v.n = 4'(n); v.c = 4'(c); v.ti = 8'(ti);
    v.fp = 8'(fp); v.nc = 4'(nc); v.tf = 8'(tf);
    v.rj = rj[0]; v.ov = ov[0];
    return v;
  endfunction

  // Independent integer reference for random stimulus.
  function automatic vec_t model(input logic c_, input int up, input int n, input int c,
                                 input int ti);
    int sum;
    vec_t v;
    v = mk(c_, up, n, c, ti, 0, c, ti, 0, 0);
    if (c_) begin
      if (n > c) begin
        v.rj = 1'b1;
      end else begin
        sum  = ti + up * n;
        v.fp = 8'(up * n);
        v.nc = 4'(c - n);
        if (sum > 255) begin
          v.ov = 1'b1;
          v.tf = SAT ? 8'd255 : 8'(sum - 256);
        end else begin
          v.tf = 8'(sum);
        end
      end
    end else begin
      if (c + n > 15) begin
        v.nc = 4'd15;
        v.ov = 1'b1;
      end else begin
        v.nc = 4'(c + n);
      end
    end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".fprice"},       32'(fprice),       0);
    chk({tag, ".new_ct"},       32'(new_ct),       0);
    chk({tag, ".tprice_final"}, 32'(tprice_final), 0);
    chk({tag, ".reject"},       32'(reject),       0);
    chk({tag, ".ovf"},          32'(ovf),          0);
  endtask

  task automatic drive(input vec_t v);
    ctrl = v.ctrl; uprice = v.up; ncel = v.n; ct = v.c; tprice_init = v.ti;
    sb_q.push_back(v);
  endtask

  task automatic pop_check(input string tag);
    vec_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got none, expected an entry", tag);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, ".fprice"},       32'(fprice),       32'(e.fp));
    chk({tag, ".new_ct"},       32'(new_ct),       32'(e.nc));
    chk({tag, ".tprice_final"}, 32'(tprice_final), 32'(e.tf));
    chk({tag, ".reject"},       32'(reject),       32'(e.rj));
    chk({tag, ".ovf"},          32'(ovf),          32'(e.ov));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  initial begin
    vec_t v;
    string tag;
    vecs[0]  = mk(1, 8, 3, 15, 0,    24, 12, 24, 0, 0);
    vecs[1]  = mk(1, 2, 2, 12, 24,    4, 10, 28, 0, 0);
    vecs[2]  = mk(1, 5, 6, 4, 10,     0, 4, 10, 1, 0);
    vecs[3]  = mk(1, 15, 15, 15, 100, 225, 0, SAT ? 255 : 69, 0, 1);
    vecs[4]  = mk(0, 7, 9, 10, 50,    0, 15, 50, 0, 1);
    vecs[5]  = mk(0, 3, 3, 4, 50,     0, 7, 50, 0, 0);
    vecs[6]  = mk(1, 9, 0, 5, 77,     0, 5, 77, 0, 0);
    vecs[7]  = mk(1, 3, 6, 6, 200,   18, 0, 218, 0, 0);
    vecs[8]  = mk(1, 5, 11, 11, 200, 55, 0, 255, 0, 0);
    vecs[9]  = mk(1, 8, 7, 9, 200,   56, 2, SAT ? 255 : 0, 0, 1);
    vecs[10] = mk(0, 0, 5, 10, 3,     0, 15, 3, 0, 0);
    vecs[11] = mk(1, 15, 15, 14, 250, 0, 14, 250, 1, 0);

    reset = 1'b0;
    ctrl = 1'b1; uprice = 4'd8; ncel = 4'd3; ct = 4'd15; tprice_init = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset_hold");
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      tag = $sformatf("vec%0d", i);
      run_vec(vecs[i], tag);
    end

    for (int k = 0; k < 40; k++) begin
      v = model(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 15), $urandom_range(0, 255));
      tag = $sformatf("rnd%0d", k);
      run_vec(v, tag);
    end

    // Asynchronous reset in the middle of a sale.
    run_vec(vecs[0], "pre_rst");
    #3;
    reset = 1'b0;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #1;
    chk_zero("rst_edge");
    @(negedge clk);
    drive(vecs[1]);
    reset = 1'b1;
    #1;
    chk_zero("rst_release");
    @(posedge clk);
    #1;
    pop_check("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
